// File: rtl/fault_pkg.sv
// Shared opcode constants, invalid-opcode sentinel and FSM state encoding
// for the ALU fault monitor.
package fault_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [31:0] INVALID_RESULT = 32'hDEADBEEF;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ALARM = 1'b1
  } state_t;

endpackage

// File: rtl/alu_golden.sv
// Independent combinational reference for the ALU under test: recomputes the
// expected result from the operands and opcode.
module alu_golden
  import fault_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  opcode,
  output logic [31:0] expected
);

  // Expected-result selection; unknown opcodes map to the sentinel value
  always_comb begin
    expected = INVALID_RESULT;
    case (opcode)
      OP_ADD:  expected = a + b;
      OP_SUB:  expected = a - b;
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_XOR:  expected = a ^ b;
      default: expected = INVALID_RESULT;
    endcase
  end

endmodule

// File: rtl/alu_fault_monitor.sv
// Two-stage checker comparing observed ALU results against alu_golden, with
// saturating counters and a sticky alarm. FAULT_CAPTURE_EN adds first-fault capture.
module alu_fault_monitor
  import fault_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [2:0]       in_opcode,
  input  logic [31:0]      in_result,
  input  logic             clear,
  output logic             chk_valid,
  output logic             chk_fault,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] fault_count,
  output logic             alarm
`ifdef FAULT_CAPTURE_EN
  ,
  output logic [2:0]       cap_opcode,
  output logic [31:0]      cap_expected,
  output logic [31:0]      cap_observed
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  state_t           state_r;
  logic             xfer_s;
  logic [31:0]      golden_s;
  logic             s1_valid_r;
  logic [31:0]      s1_expected_r;
  logic [31:0]      s1_observed_r;
  logic             chk_valid_r;
  logic             chk_fault_r;
  logic [CNT_W-1:0] check_count_r;
  logic [CNT_W-1:0] fault_count_r;
  logic             fault_inc_s;
  logic [CNT_W-1:0] check_next_s;
  logic [CNT_W-1:0] fault_next_s;

  assign in_ready    = (state_r == ST_RUN) && !clear;
  assign xfer_s      = in_valid && in_ready;
  assign chk_valid   = chk_valid_r;
  assign chk_fault   = chk_fault_r;
  assign check_count = check_count_r;
  assign fault_count = fault_count_r;
  assign alarm       = (state_r == ST_ALARM);

  alu_golden u_golden (
    .a        (in_a),
    .b        (in_b),
    .opcode   (in_opcode),
    .expected (golden_s)
  );

  // Stage 1 captures operands/expected; stage 2 produces the compare result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r    <= 1'b0;
      s1_expected_r <= 32'h0000_0000;
      s1_observed_r <= 32'h0000_0000;
      chk_valid_r   <= 1'b0;
      chk_fault_r   <= 1'b0;
    end else if (clear) begin
      s1_valid_r    <= 1'b0;
      chk_valid_r   <= 1'b0;
      chk_fault_r   <= 1'b0;
    end else begin
      s1_valid_r  <= xfer_s;
      chk_valid_r <= s1_valid_r;
      chk_fault_r <= s1_valid_r && (s1_expected_r != s1_observed_r);
      if (xfer_s) begin
        s1_expected_r <= golden_s;
        s1_observed_r <= in_result;
      end
    end
  end

  // Saturating next-count values for the completing check
  always_comb begin
    fault_inc_s  = chk_valid_r && chk_fault_r;
    check_next_s = check_count_r;
    fault_next_s = fault_count_r;
    if (chk_valid_r && (check_count_r != CNT_MAX)) begin
      check_next_s = check_count_r + CNT_ONE;
    end else begin
      check_next_s = check_count_r;
    end
    if (fault_inc_s && (fault_count_r != CNT_MAX)) begin
      fault_next_s = fault_count_r + CNT_ONE;
    end else begin
      fault_next_s = fault_count_r;
    end
  end

  // Counters and RUN/ALARM state; clear outranks any completing check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      check_count_r <= CNT_ZERO;
      fault_count_r <= CNT_ZERO;
      state_r       <= ST_RUN;
    end else if (clear) begin
      check_count_r <= CNT_ZERO;
      fault_count_r <= CNT_ZERO;
      state_r       <= ST_RUN;
    end else begin
      check_count_r <= check_next_s;
      fault_count_r <= fault_next_s;
      case (state_r)
        ST_RUN: begin
          if (fault_inc_s && (fault_next_s >= THRESH_C)) begin
            state_r <= ST_ALARM;
          end
        end
        ST_ALARM: state_r <= ST_ALARM;
        default:  state_r <= ST_RUN;
      endcase
    end
  end

`ifdef FAULT_CAPTURE_EN
  logic [2:0]  s1_opcode_r;
  logic [2:0]  s2_opcode_r;
  logic [31:0] s2_expected_r;
  logic [31:0] s2_observed_r;

  // Side pipeline carrying the transaction details alongside the check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_opcode_r   <= 3'b000;
      s2_opcode_r   <= 3'b000;
      s2_expected_r <= 32'h0000_0000;
      s2_observed_r <= 32'h0000_0000;
    end else begin
      if (xfer_s) begin
        s1_opcode_r <= in_opcode;
      end
      if (s1_valid_r) begin
        s2_opcode_r   <= s1_opcode_r;
        s2_expected_r <= s1_expected_r;
        s2_observed_r <= s1_observed_r;
      end
    end
  end

  // A zero fault count means no fault has been captured since reset/clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_opcode   <= 3'b000;
      cap_expected <= 32'h0000_0000;
      cap_observed <= 32'h0000_0000;
    end else if (clear) begin
      cap_opcode   <= 3'b000;
      cap_expected <= 32'h0000_0000;
      cap_observed <= 32'h0000_0000;
    end else if (fault_inc_s && (fault_count_r == CNT_ZERO)) begin
      cap_opcode   <= s2_opcode_r;
      cap_expected <= s2_expected_r;
      cap_observed <= s2_observed_r;
    end
  end
`endif

endmodule
